// File: rtl/branch_predict_ctrl.sv
// Branch prediction and redirect controller: direct-mapped BTB with 2-bit
// counters, IF-stage lookup, EX-stage mispredict resolve, training and perf counters.
module branch_predict_ctrl #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned IDX_W   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        BranchValidE,
    input  logic [31:0] PCE,
    input  logic        BranchE,
    input  logic [31:0] BrTargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        RedirectE,
    output logic [31:0] RedirectPCE,
    output logic        FlushD,
    output logic        FlushE,
    output logic [31:0] BranchCnt,
    output logic [31:0] MispredCnt
);

    localparam int unsigned TAG_W = 32 - IDX_W - 2;
    localparam logic [1:0] CTR_WEAK_NT = 2'b01;
    localparam logic [1:0] CTR_WEAK_T  = 2'b10;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0] idx_f;
    logic [TAG_W-1:0] tag_f;
    logic             hit_f;

    logic [IDX_W-1:0] idx_e;
    logic [TAG_W-1:0] tag_e;
    logic             hit_e;
    logic [31:0]      pce_plus4;

    logic             redirect;
    logic [31:0]      redirect_pc;

    // IF lookup; reset forces a not-taken prediction regardless of array contents
    always_comb begin
        idx_f       = PCF[IDX_W+1:2];
        tag_f       = PCF[31:IDX_W+2];
        hit_f       = rst_n && valid_q[idx_f] && (tag_q[idx_f] == tag_f);
        PredTakenF  = hit_f && ctr_q[idx_f][1];
        PredTargetF = hit_f ? target_q[idx_f] : PCF + 32'd4;
    end

    // EX resolve against the piped prediction
    always_comb begin
        idx_e       = PCE[IDX_W+1:2];
        tag_e       = PCE[31:IDX_W+2];
        hit_e       = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
        pce_plus4   = PCE + 32'd4;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        if (BranchValidE) begin
            redirect_pc = pce_plus4;
            if (!PredTakenE && BranchE) begin
                redirect    = 1'b1;
                redirect_pc = BrTargetE;
            end else if (PredTakenE && !BranchE) begin
                redirect    = 1'b1;
                redirect_pc = pce_plus4;
            end else if (PredTakenE && BranchE && (PredTargetE != BrTargetE)) begin
                redirect    = 1'b1;
                redirect_pc = BrTargetE;
            end
        end
    end

    assign RedirectE   = redirect;
    assign RedirectPCE = redirect_pc;
    assign FlushD      = redirect;
    assign FlushE      = redirect;

    // valid bits and counters carry reset state; training is suppressed while in reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= CTR_WEAK_NT;
            end
        end else if (BranchValidE) begin
            if (hit_e) begin
                if (BranchE) begin
                    if (ctr_q[idx_e] != 2'b11) begin
                        ctr_q[idx_e] <= ctr_q[idx_e] + 2'd1;
                    end
                end else if (ctr_q[idx_e] != 2'b00) begin
                    ctr_q[idx_e] <= ctr_q[idx_e] - 2'd1;
                end
            end else if (BranchE) begin
                valid_q[idx_e] <= 1'b1;
                ctr_q[idx_e]   <= CTR_WEAK_T;
            end
        end
    end

    // tags and targets need no reset; they only matter behind a valid bit
    always_ff @(posedge clk) begin
        if (rst_n && BranchValidE && BranchE) begin
            target_q[idx_e] <= BrTargetE;
            if (!hit_e) begin
                tag_q[idx_e] <= tag_e;
            end
        end
    end

    // performance counters wrap naturally at 32 bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            BranchCnt  <= 32'd0;
            MispredCnt <= 32'd0;
        end else begin
            if (BranchValidE) begin
                BranchCnt <= BranchCnt + 32'd1;
            end
            if (redirect) begin
                MispredCnt <= MispredCnt + 32'd1;
            end
        end
    end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
Branch prediction and redirect controller for the 5-stage RV32I pipeline.
- Holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Predicts taken/target for the fetch PC in IF.
- Compares the prediction against the EX-stage branch decision (BEQ/BNE outcome) and issues redirect and flush when they differ.
- Trains the BTB and keeps branch and mispredict performance counters.

Parameters:
- ENTRIES, 64, number of BTB entries; must be a power of 2.
- IDX_W, 6, log2(ENTRIES). Index is PC[IDX_W+1:2]; tag is PC[31:IDX_W+2].

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- PCF  in  32  fetch-stage PC.
- PredTakenF  out  1  IF prediction: taken.
- PredTargetF  out  32  IF predicted target; valid when PredTakenF=1.
- BranchValidE  in  1  EX holds a real conditional branch (not a bubble, not stalled).
- PCE  in  32  PC of the EX-stage instruction.
- BranchE  in  1  actual outcome from branch decision logic (1 = taken).
- BrTargetE  in  32  computed branch target (PCE + imm).
- PredTakenE  in  1  prediction piped from IF to EX alongside the instruction.
- PredTargetE  in  32  predicted target piped to EX.
- RedirectE  out  1  mispredict; fetch must load RedirectPCE.
- RedirectPCE  out  32  correct next PC.
- FlushD  out  1  flush the IF/ID register; equals RedirectE.
- FlushE  out  1  flush the ID/EX register; equals RedirectE.
- BranchCnt  out  32  retired-branch counter.
- MispredCnt  out  32  mispredict counter.

Behaviour:
- Lookup (combinational)
  - idx = PCF[IDX_W+1:2].
  - hit = valid[idx] && tag[idx]==PCF[31:IDX_W+2].
  - PredTakenF = hit && ctr[idx][1].
  - PredTargetF = hit ? target[idx] : PCF+4.
- Resolve (combinational, gated by BranchValidE; all resolve outputs are 0 when BranchValidE=0)
  - Pred NT, actual T: RedirectE=1, RedirectPCE=BrTargetE.
  - Pred T, actual NT: RedirectE=1, RedirectPCE=PCE+4.
  - Pred T, actual T, PredTargetE!=BrTargetE: RedirectE=1, RedirectPCE=BrTargetE.
  - Otherwise: RedirectE=0, RedirectPCE=PCE+4 (don't-care).
  - FlushD = FlushE = RedirectE; 0-cycle latency from EX inputs.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Train (clocked, when BranchValidE=1), at entry e = PCE[IDX_W+1:2]:
  - Hit and taken: ctr saturating increment (11 stays 11); target[e] <= BrTargetE.
  - Hit and not taken: ctr saturating decrement (00 stays 00); target unchanged.
  - Miss and taken: allocate/replace the entry: valid=1, tag=PCE[31:IDX_W+2], target=BrTargetE, ctr=10.
  - Miss and not taken: no change.
- Read/write same index in one cycle: lookup returns the old contents; the write is visible from the next cycle.
- Perf counters (clocked):
  - BranchCnt += 1 on each BranchValidE=1.
  - MispredCnt += 1 on each cycle with RedirectE=1.
  - Both are 32-bit and wrap 0xFFFFFFFF -> 0.
- Reset (rst_n=0 at a rising edge, including mid-operation):
  - All valid <= 0, all ctr <= 01; tags and targets are don't-care.
  - BranchCnt <= 0, MispredCnt <= 0.
  - Training is suppressed in that cycle.
  - Outputs during and after reset: PredTakenF=0, PredTargetF=PCF+4. RedirectE/FlushD/FlushE follow their combinational inputs; the pipeline holds BranchValidE=0 in reset.
- Implementation: arrays in flops; no multicycle paths.

Test Plan:
- Reset, then PCF=0x100 -> PredTakenF=0, PredTargetF=0x104; BranchCnt=MispredCnt=0.
- Cold miss: BranchValidE=1, PCE=0x100, BranchE=1, BrTargetE=0x80, PredTakenE=0 -> RedirectE=FlushD=FlushE=1, RedirectPCE=0x80, MispredCnt=1. Next cycle PCF=0x100 -> PredTakenF=1, PredTargetF=0x80.
- Training: same branch taken twice more, then not-taken once (PredTakenE=1).
  - The not-taken resolve gives RedirectE=1, RedirectPCE=0x104.
  - Counter path 10->11->11->10; PredTakenF stays 1.
  - A second not-taken gives ctr=01 and PredTakenF=0.
- Alias: PCE=0x100+4*ENTRIES=0x200, taken to 0x300 -> entry replaced; PCF=0x100 then misses, PredTakenF=0.
- Target mismatch: PredTakenE=1, PredTargetE=0x80, BranchE=1, BrTargetE=0x90 -> RedirectE=1, RedirectPCE=0x90; entry target updated to 0x90.
- Same-cycle hazard and mid-run reset:
  - Train and look up the same idx in one cycle -> old prediction seen that cycle, new one the next.
  - Drop rst_n for one edge mid-run -> all predictions NT and counters cleared on the next cycle.
